// File: rtl/axis_spi_controller.sv
// axis_spi_controller: mode-0 SPI initiator moving AXI4-Stream bytes out on MOSI and MISO bytes back.
// Optional mid-frame idle timeout is built only when AXIS_SPI_CONTROLLER_TIMEOUT_EN is defined.
module axis_spi_controller #(
   parameter int CLK_DIV      = 4,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic       clock,
   input  logic       reset,
   output logic       SCK,
   output logic       SSEL,
   output logic       MOSI,
   input  logic       MISO,
   input  logic       s_tvalid,
   output logic       s_tready,
   input  logic       s_tlast,
   input  logic [7:0] s_tdata,
   output logic       m_tvalid,
   input  logic       m_tready,
   output logic       m_tlast,
   output logic [7:0] m_tdata,
   output logic       timeout_o
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_NEXT  = 2'd2;
   localparam logic [1:0] ST_END   = 2'd3;
   localparam int DW = $clog2(CLK_DIV + 1);

   generate
      if (CLK_DIV < 2 || IDLE_TIMEOUT < 1) begin : g_bad_param
         $error("axis_spi_controller: CLK_DIV must be >= 2 and IDLE_TIMEOUT >= 1");
      end
   endgenerate

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [3:0]    half_q, half_d;
   logic [7:0]    tx_q, tx_d;
   logic [7:0]    rx_q, rx_d;
   logic          last_q, last_d;
   logic          sck_q, sck_d;
   logic          ssel_q, ssel_d;
   logic          mosi_q, mosi_d;
   logic          rdy_q;
   logic          m_valid_q, m_valid_d;
   logic          m_last_q, m_last_d;
   logic [7:0]    m_data_q, m_data_d;
   logic          s_hs;
   logic          to_expire;

   // Only accept a byte when the receive register is guaranteed free at its completion.
   assign s_tready  = rdy_q && (state_q == ST_IDLE || state_q == ST_NEXT) && (!m_valid_q || m_tready);
   assign s_hs      = s_tvalid && s_tready;
   assign SCK       = sck_q;
   assign SSEL      = ssel_q;
   assign MOSI      = mosi_q;
   assign m_tvalid  = m_valid_q;
   assign m_tlast   = m_last_q;
   assign m_tdata   = m_data_q;

`ifdef AXIS_SPI_CONTROLLER_TIMEOUT_EN
   localparam int TW = $clog2(IDLE_TIMEOUT + 1);
   logic [TW-1:0] to_q, to_d;
   logic          timeout_q, timeout_d;

   assign to_expire = (state_q == ST_NEXT) && !s_hs && (to_q == TW'(IDLE_TIMEOUT - 1));
   assign timeout_o = timeout_q;

   always_comb begin
      to_d      = to_q + TW'(1);
      timeout_d = 1'b0;
      if (state_q != ST_NEXT || s_hs) begin
         to_d = '0;
      end else if (to_expire) begin
         to_d      = '0;
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         to_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         to_q      <= to_d;
         timeout_q <= timeout_d;
      end
   end
`else
   assign to_expire = 1'b0;
   assign timeout_o = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      half_d    = half_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      last_d    = last_q;
      sck_d     = sck_q;
      ssel_d    = ssel_q;
      mosi_d    = mosi_q;
      m_valid_d = m_valid_q && !m_tready;
      m_last_d  = m_last_q;
      m_data_d  = m_data_q;
      case (state_q)
         ST_IDLE, ST_NEXT: begin
            if (s_hs) begin
               state_d = ST_SHIFT;
               div_d   = '0;
               half_d  = '0;
               tx_d    = {s_tdata[6:0], 1'b0};
               mosi_d  = s_tdata[7];
               last_d  = s_tlast;
               ssel_d  = 1'b0;
            end else if (to_expire) begin
               state_d = ST_END;
               div_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (div_q == DW'(CLK_DIV - 1)) begin
               div_d  = '0;
               half_d = half_q + 4'd1;
               if (!half_q[0]) begin
                  sck_d = 1'b1;
                  rx_d  = {rx_q[6:0], MISO};
               end else begin
                  sck_d = 1'b0;
                  // Last falling edge: hand the byte over, MOSI keeps its final bit.
                  if (half_q == 4'd15) begin
                     m_data_d  = rx_q;
                     m_last_d  = last_q;
                     m_valid_d = 1'b1;
                     state_d   = last_q ? ST_END : ST_NEXT;
                  end else begin
                     mosi_d = tx_q[7];
                     tx_d   = {tx_q[6:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         ST_END: begin
            // First END cycle is SSEL hold; the remaining CLK_DIV cycles are SSEL-high guard.
            ssel_d = 1'b1;
            if (div_q == DW'(CLK_DIV)) begin
               div_d   = '0;
               state_d = ST_IDLE;
               mosi_d  = 1'b0;
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         div_q     <= '0;
         half_q    <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         last_q    <= 1'b0;
         sck_q     <= 1'b0;
         ssel_q    <= 1'b1;
         mosi_q    <= 1'b0;
         rdy_q     <= 1'b0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         half_q    <= half_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         last_q    <= last_d;
         sck_q     <= sck_d;
         ssel_q    <= ssel_d;
         mosi_q    <= mosi_d;
         rdy_q     <= 1'b1;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         m_data_q  <= m_data_d;
      end
   end
endmodule

// File: tb/tb_axis_spi_controller.sv
// tb_axis_spi_controller: directed table vectors plus hand sequences for stall, reset abort,
// CLK_DIV=2 timing and (when AXIS_SPI_CONTROLLER_TIMEOUT_EN is defined) the idle timeout.
module tb_axis_spi_controller;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       SCK, SSEL, MOSI, MISO;
   logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
   logic [7:0] s_tdata = 8'h00;
   logic       m_tvalid, m_tlast, m_tready = 1'b1;
   logic [7:0] m_tdata;
   logic       timeout_o;

   logic       sck2, ssel2, mosi2, to2;
   logic       s2_tvalid = 1'b0, s2_tlast = 1'b0, s2_tready;
   logic [7:0] s2_tdata = 8'h00;
   logic       m2_tvalid, m2_tlast, m2_tready = 1'b1;
   logic [7:0] m2_tdata;

   always #5 clock = ~clock;

   axis_spi_controller #(.CLK_DIV(4), .IDLE_TIMEOUT(16)) dut (
      .clock(clock), .reset(reset), .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
      .timeout_o(timeout_o));

   // Second instance with MISO looped back from MOSI, so it receives what it sends.
   axis_spi_controller #(.CLK_DIV(2), .IDLE_TIMEOUT(16)) dut2 (
      .clock(clock), .reset(reset), .SCK(sck2), .SSEL(ssel2), .MOSI(mosi2), .MISO(mosi2),
      .s_tvalid(s2_tvalid), .s_tready(s2_tready), .s_tlast(s2_tlast), .s_tdata(s2_tdata),
      .m_tvalid(m2_tvalid), .m_tready(m2_tready), .m_tlast(m2_tlast), .m_tdata(m2_tdata),
      .timeout_o(to2));

   typedef struct {
      logic [7:0] tx;
      logic       last;
      logic [7:0] miso;
      logic [7:0] exp_data;
      logic       exp_last;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int hs_cyc [0:7];

   // Target model: byte k of miso_arr is driven MSB first, advancing after each SCK rise.
   logic [7:0] miso_arr [0:7];
   int         rise_cnt = 0;
   int         rise_base = 0;
   logic [5:0] bit_idx;
   always_comb begin
      bit_idx = 6'(rise_cnt - rise_base);
      MISO    = miso_arr[bit_idx[5:3]][~bit_idx[2:0]];
   end

   always @(posedge clock) cyc++;

   // Waveform monitor for dut: MOSI at rises, SCK run lengths while selected, SSEL run lengths.
   logic       sck_prev = 1'b0, ssel_prev = 1'b1;
   logic [7:0] mosi_sr = 8'h00;
   int low_run = 0, hi_run = 0, max_low = 0, max_hi = 0, min_hi = 1000;
   int ssel_low = 0, ssel_high = 0, clr_req = 0, clr_ack = 0;
   int ssel_lows[$];
   int ssel_highs[$];
   always @(negedge clock) begin
      if (clr_req != clr_ack) begin
         clr_ack = clr_req; max_low = 0; max_hi = 0; min_hi = 1000;
      end
      if (SCK && !sck_prev) begin
         rise_cnt++;
         mosi_sr = {mosi_sr[6:0], MOSI};
      end
      if (!SSEL && !SCK) low_run++;
      else begin
         if (low_run > max_low) max_low = low_run;
         low_run = 0;
      end
      if (SCK) hi_run++;
      else if (hi_run > 0) begin
         if (hi_run > max_hi) max_hi = hi_run;
         if (hi_run < min_hi) min_hi = hi_run;
         hi_run = 0;
      end
      if (!SSEL) begin
         ssel_low++;
         if (ssel_prev) begin ssel_highs.push_back(ssel_high); ssel_high = 0; end
      end else begin
         ssel_high++;
         if (!ssel_prev) begin ssel_lows.push_back(ssel_low); ssel_low = 0; end
      end
      sck_prev  = SCK;
      ssel_prev = SSEL;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic timed_out(input string nm);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting", nm);
   endtask

   task automatic wait_s_ready(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clock);
         if (s_tready) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_m_valid(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clock);
         if (m_tvalid) begin ok = 1'b1; break; end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [5];
      bit   ok;
      int   n0, h0, cnt, hi_c, lo_c, rises;
      logic prev;
`ifdef AXIS_SPI_CONTROLLER_TIMEOUT_EN
      localparam int STALL = 10;
`else
      localparam int STALL = 50;
`endif

      vecs[0] = '{8'hA5, 1'b1, 8'h3C, 8'h3C, 1'b1};
      vecs[1] = '{8'h01, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[2] = '{8'h02, 1'b0, 8'h01, 8'h01, 1'b0};
      vecs[3] = '{8'h83, 1'b1, 8'h02, 8'h02, 1'b1};
      vecs[4] = '{8'hFF, 1'b1, 8'h81, 8'h81, 1'b1};
      for (int i = 0; i < 8; i++) miso_arr[i] = 8'h00;

      // Reset state
      repeat (2) @(negedge clock);
      check("rst_sck", SCK, 0);
      check("rst_ssel", SSEL, 1);
      check("rst_mosi", MOSI, 0);
      check("rst_s_tready", s_tready, 0);
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_m_tdata", m_tdata, 8'h00);
      check("rst_timeout", timeout_o, 0);
      reset = 1'b0;
      #1 check("rdy_same_cycle", s_tready, 0);
      @(negedge clock);
      check("rdy_next_cycle", s_tready, 1);

      // Table: frame {A5}, frame {01,02,83} with echo target, frame {FF}, streamed back to back
      @(posedge clock); #1;
      rise_base = rise_cnt;
      for (int i = 0; i < 5; i++) miso_arr[i] = vecs[i].miso;
      n0 = ssel_lows.size();
      h0 = ssel_highs.size();
      clr_req++;
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               s_tdata  = vecs[i].tx;
               s_tlast  = vecs[i].last;
               s_tvalid = 1'b1;
               wait_s_ready(ok);
               if (!ok) begin timed_out("tbl_s_hs"); break; end
               hs_cyc[i] = cyc;
               @(posedge clock); #1;
            end
            s_tvalid = 1'b0;
         end
         begin
            for (int i = 0; i < 5; i++) begin
               wait_m_valid(ok);
               if (!ok) begin timed_out("tbl_m_valid"); break; end
               check($sformatf("tbl%0d_data", i), m_tdata, vecs[i].exp_data);
               check($sformatf("tbl%0d_last", i), m_tlast, vecs[i].exp_last);
               check($sformatf("tbl%0d_mosi", i), mosi_sr, vecs[i].tx);
               check($sformatf("tbl%0d_latency", i), cyc - hs_cyc[i], 65);
               @(posedge clock); #1;
            end
         end
      join
      repeat (20) @(posedge clock);
      #1;
      check("tbl_rises", rise_cnt - rise_base, 40);
      check("tbl_frames", ssel_lows.size() - n0, 3);
      if (ssel_lows.size() >= n0 + 3) begin
         check("ssel_low_1byte", ssel_lows[n0], 65);
         check("ssel_low_3byte", ssel_lows[n0 + 1], 195);
         check("ssel_low_last", ssel_lows[n0 + 2], 65);
      end
      if (ssel_highs.size() >= h0 + 3) begin
         check("ssel_gap_b2b_1", ssel_highs[h0 + 1], 5);
         check("ssel_gap_b2b_2", ssel_highs[h0 + 2], 5);
      end else timed_out("ssel_gap_count");
      check("sck_max_low", max_low, 5);
      check("sck_max_high", max_hi, 4);
      check("sck_min_high", min_hi, 4);
      check("mosi_idle", MOSI, 0);

      // Backpressure: first beat left unconsumed, second byte must wait intact
      rise_base = rise_cnt;
      miso_arr[0] = 8'h55;
      miso_arr[1] = 8'hAA;
      m_tready = 1'b0;
      s_tdata = 8'h11; s_tlast = 1'b0; s_tvalid = 1'b1;
      wait_s_ready(ok);
      if (!ok) timed_out("bp_hs1");
      @(posedge clock); #1;
      s_tdata = 8'h22; s_tlast = 1'b1;
      wait_m_valid(ok);
      if (!ok) timed_out("bp_beat1");
      check("bp_data1", m_tdata, 8'h55);
      check("bp_last1", m_tlast, 0);
      cnt = 0;
      for (int k = 0; k < STALL; k++) begin
         @(negedge clock);
         if (s_tready || SCK || SSEL || !m_tvalid || m_tdata != 8'h55) cnt++;
      end
      check("bp_stall_cycles_bad", cnt, 0);
      m_tready = 1'b1;
      #1 check("bp_resume_ready", s_tready, 1);
      @(posedge clock); #1;
      s_tvalid = 1'b0;
      wait_m_valid(ok);
      if (!ok) timed_out("bp_beat2");
      check("bp_data2", m_tdata, 8'hAA);
      check("bp_last2", m_tlast, 1);
      check("bp_mosi2", mosi_sr, 8'h22);
      repeat (12) @(negedge clock);

      // CLK_DIV=2 instance: loopback byte, 2-cycle SCK phases, 33-cycle latency
      s2_tdata = 8'h96; s2_tlast = 1'b1; s2_tvalid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         if (s2_tready) begin ok = 1'b1; break; end
      end
      if (!ok) timed_out("cd2_hs");
      @(posedge clock); #1;
      s2_tvalid = 1'b0;
      cnt = 0; hi_c = 0; lo_c = 0; rises = 0; prev = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         cnt++;
         if (sck2 && !prev) rises++;
         if (sck2) hi_c++;
         if (!sck2 && !ssel2) lo_c++;
         prev = sck2;
         if (m2_tvalid) break;
      end
      check("cd2_latency", cnt, 33);
      check("cd2_rises", rises, 8);
      check("cd2_high_cycles", hi_c, 16);
      check("cd2_low_cycles", lo_c, 17);
      check("cd2_data", m2_tdata, 8'h96);
      check("cd2_last", m2_tlast, 1);
      repeat (10) @(negedge clock);

      // Reset during bit 4 aborts the byte at once
      @(posedge clock); #1;
      rise_base = rise_cnt;
      miso_arr[0] = 8'h99;
      s_tdata = 8'h5A; s_tlast = 1'b1; s_tvalid = 1'b1;
      wait_s_ready(ok);
      if (!ok) timed_out("rst_hs");
      @(posedge clock); #1;
      s_tvalid = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clock); #1;
         if (rise_cnt - rise_base >= 5) begin ok = 1'b1; break; end
      end
      if (!ok) timed_out("rst_bit4");
      check("abort_pre_sck", SCK, 1);
      check("abort_pre_ssel", SSEL, 0);
      reset = 1'b1;
      #1;
      check("abort_sck", SCK, 0);
      check("abort_ssel", SSEL, 1);
      repeat (2) @(negedge clock);
      check("abort_m_tvalid", m_tvalid, 0);
      reset = 1'b0;
      #1 check("abort_rdy_low", s_tready, 0);
      @(negedge clock);
      check("abort_rdy_high", s_tready, 1);
      cnt = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clock);
         if (m_tvalid) cnt++;
      end
      check("abort_no_beat", cnt, 0);
      @(posedge clock); #1;
      rise_base = rise_cnt;
      miso_arr[0] = 8'h5A;
      s_tdata = 8'hC3; s_tlast = 1'b1; s_tvalid = 1'b1;
      wait_s_ready(ok);
      if (!ok) timed_out("post_rst_hs");
      hs_cyc[0] = cyc;
      @(posedge clock); #1;
      s_tvalid = 1'b0;
      wait_m_valid(ok);
      if (!ok) timed_out("post_rst_beat");
      check("post_rst_data", m_tdata, 8'h5A);
      check("post_rst_last", m_tlast, 1);
      check("post_rst_mosi", mosi_sr, 8'hC3);
      check("post_rst_latency", cyc - hs_cyc[0], 65);
      repeat (12) @(negedge clock);

`ifdef AXIS_SPI_CONTROLLER_TIMEOUT_EN
      // Idle timeout: non-last byte then nothing; one pulse 16 cycles into NEXT
      begin
         int to_at, pulses, extra;
         logic ssel_at, ssel_after;
         @(posedge clock); #1;
         rise_base = rise_cnt;
         miso_arr[0] = 8'h6B;
         s_tdata = 8'h7E; s_tlast = 1'b0; s_tvalid = 1'b1;
         wait_s_ready(ok);
         if (!ok) timed_out("to_hs");
         @(posedge clock); #1;
         s_tvalid = 1'b0;
         wait_m_valid(ok);
         if (!ok) timed_out("to_beat");
         check("to_data", m_tdata, 8'h6B);
         check("to_last", m_tlast, 0);
         to_at = -1; pulses = 0; extra = 0; ssel_at = 1'b1; ssel_after = 1'b0;
         for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (m_tvalid) extra++;
            if (to_at > 0 && k == to_at + 1) ssel_after = SSEL;
            if (timeout_o) begin
               pulses++;
               if (to_at < 0) begin to_at = k; ssel_at = SSEL; end
            end
         end
         check("to_when", to_at, 16);
         check("to_pulses", pulses, 1);
         check("to_ssel_at", ssel_at, 0);
         check("to_ssel_after", ssel_after, 1);
         check("to_no_extra_beat", extra, 0);
      end
`else
      check("timeout_tied", timeout_o, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
